rr_arbiter_8: RTL and testbench

Round-robin arbiter sharing one resource among eight requesters, issuing a registered one-hot grant plus its 3-bit index. It sits in front of any 8-way shared datapath that is steered by a 3-bit select, so the select and its decoded enable always agree. Grants are held while the winner keeps its request high, with an optional hold-time limit that forces release.

---
 rtl/rr_arbiter_8_pkg.sv | 13 +
 rtl/grant_decoder_3to8.sv | 15 +
 rtl/rr_arbiter_8.sv | 109 ++++++++++
 tb/tb_rr_arbiter_8.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: FSM encoding and sizes.
package rr_arbiter_8_pkg;

  localparam int NREQ  = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/grant_decoder_3to8.sv
// Index-to-one-hot decoder; output is all-zero while the enable is low.
module grant_decoder_3to8
  import rr_arbiter_8_pkg::*;
(
  input  logic             en_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [NREQ-1:0]  onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for eight requesters with registered grant/index and an
// optional per-tenure hold limit.
//   state    | meaning
//   ST_IDLE  | arbitrate among current requests starting at ptr
//   ST_GRANT | winner owns the resource until it drops req or hits MAX_HOLD
//   ST_GAP   | one dead cycle between tenures, no arbitration
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             busy,
  output logic             timeout
);

  localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             hold_expired;

  // First requester at or above p, falling back to the lowest set bit overall.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                                input logic [IDX_W-1:0] p);
    logic [NREQ-1:0] masked;
    logic            found;
    rr_pick = '0;
    found   = 1'b0;
    for (int i = 0; i < NREQ; i++) masked[i] = r[i] && (i >= int'(p));
    for (int i = 0; i < NREQ; i++) begin
      if (masked[i] && !found) begin
        rr_pick = IDX_W'(i);
        found   = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (r[i] && !found) begin
        rr_pick = IDX_W'(i);
        found   = 1'b1;
      end
    end
  endfunction

  assign hold_expired = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          idx_d   = rr_pick(req, ptr_q);
          cnt_d   = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!req[idx_q] || hold_expired) begin
          state_d   = ST_GAP;
          ptr_d     = idx_q + 3'd1;
          timeout_d = req[idx_q];
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Grant is a pure decode of flops, so there is no req -> gnt path.
  grant_decoder_3to8 u_dec (
    .en_i     (state_q == ST_GRANT),
    .idx_i    (idx_q),
    .onehot_o (gnt)
  );

  assign busy    = (state_q == ST_GRANT);
  assign gnt_idx = idx_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: three instances (MAX_HOLD 16, 4, 0) on shared stimulus,
// each compared every cycle against a tenure-level reference model.
module tb_rr_arbiter_8;

  logic       clk;
  logic       rst;
  logic [7:0] req;

  logic [7:0] gnt_w  [3];
  logic [2:0] idx_w  [3];
  logic       busy_w [3];
  logic       to_w   [3];

  rr_arbiter_8 #(.MAX_HOLD(16)) dut (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_w[0]), .gnt_idx(idx_w[0]), .busy(busy_w[0]), .timeout(to_w[0]));

  rr_arbiter_8 #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_w[1]), .gnt_idx(idx_w[1]), .busy(busy_w[1]), .timeout(to_w[1]));

  rr_arbiter_8 #(.MAX_HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_w[2]), .gnt_idx(idx_w[2]), .busy(busy_w[2]), .timeout(to_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int hold_lim [3] = '{16, 4, 0};
  int owner    [3];
  int held     [3];
  int ptr      [3];
  int last     [3];
  bit gap      [3];
  bit to       [3];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int m = 0; m < 3; m++) begin
      owner[m] = -1;
      held[m]  = 0;
      ptr[m]   = 0;
      last[m]  = 0;
      gap[m]   = 1'b0;
      to[m]    = 1'b0;
    end
  endfunction

  // One clock edge of the tenure model, using the req value seen at that edge.
  function automatic void model_step();
    int c;
    for (int m = 0; m < 3; m++) begin
      to[m] = 1'b0;
      if (gap[m]) begin
        gap[m] = 1'b0;
      end else if (owner[m] >= 0) begin
        held[m]++;
        if (!req[owner[m]] || (hold_lim[m] != 0 && held[m] == hold_lim[m])) begin
          to[m]    = req[owner[m]];
          ptr[m]   = (owner[m] + 1) % 8;
          owner[m] = -1;
          gap[m]   = 1'b1;
        end
      end else if (req != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          c = (ptr[m] + k) % 8;
          if (req[c] && owner[m] < 0) begin
            owner[m] = c;
            last[m]  = c;
            held[m]  = 0;
          end
        end
      end
    end
  endfunction

  task automatic check_all();
    logic [7:0] eg;
    for (int m = 0; m < 3; m++) begin
      eg = (owner[m] >= 0) ? (8'h01 << owner[m]) : 8'h00;
      chk($sformatf("m%0d.gnt", m), 32'(gnt_w[m]), 32'(eg));
      chk($sformatf("m%0d.gnt_idx", m), 32'(idx_w[m]), 32'(last[m]));
      chk($sformatf("m%0d.busy", m), 32'(busy_w[m]), 32'(owner[m] >= 0));
      chk($sformatf("m%0d.timeout", m), 32'(to_w[m]), 32'(to[m]));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic flush();
    req = 8'h00;
    repeat (4) cyc();
  endtask

  initial begin
    int n80, n01, nto, n04;
    bit prev_busy;
    int order[$];

    rst = 1'b1;
    req = 8'hFF;
    model_reset();
    #1;
    check_all();
    repeat (2) cyc();
    chk("rst.gnt", 32'(gnt_w[0]), 32'h00);
    chk("rst.busy", 32'(busy_w[0]), 32'h0);
    rst = 1'b0;
    cyc();
    chk("rst.first_gnt", 32'(gnt_w[0]), 32'h01);

    // single requester held 5 cycles
    flush();
    req = 8'h08;
    n80 = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (gnt_w[0] == 8'h08) n80++;
    end
    req = 8'h00;
    cyc();
    chk("single.len", 32'(n80), 32'd5);
    chk("single.gap", 32'(gnt_w[0]), 32'h00);
    chk("single.idx", 32'(idx_w[0]), 32'd3);

    // rotation from ptr 0, each winner drops one cycle after its grant
    flush();
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    cyc();
    rst = 1'b0;
    prev_busy = 1'b0;
    for (int i = 0; i < 26; i++) begin
      req = 8'hFF;
      if (owner[0] >= 0) req[owner[0]] = 1'b0;
      cyc();
      if (busy_w[0] && !prev_busy) order.push_back(int'(idx_w[0]));
      prev_busy = busy_w[0];
    end
    chk("rot.count", 32'(order.size()), 32'd9);
    for (int i = 0; i < order.size() && i < 9; i++)
      chk($sformatf("rot.order%0d", i), 32'(order[i]), 32'(i % 8));

    // forced release with MAX_HOLD=4, ptr now 1 so bit 7 wins first
    flush();
    req = 8'h81;
    n80 = 0; n01 = 0; nto = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (i == 0) chk("force.first", 32'(gnt_w[1]), 32'h80);
      if (gnt_w[1] == 8'h80) n80++;
      if (gnt_w[1] == 8'h01) n01++;
      if (to_w[1]) nto++;
    end
    chk("force.n80", 32'(n80), 32'd4);
    chk("force.n01", 32'(n01), 32'd4);
    chk("force.nto", 32'(nto), 32'd2);

    // unlimited hold
    flush();
    req = 8'h04;
    n04 = 0; nto = 0;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (gnt_w[2] == 8'h04) n04++;
      if (to_w[2]) nto++;
    end
    chk("nohold.n04", 32'(n04), 32'd300);
    chk("nohold.nto", 32'(nto), 32'd0);

    // asynchronous reset in the middle of a grant
    flush();
    req = 8'h20;
    cyc();
    chk("midrst.pre", 32'(gnt_w[0]), 32'h20);
    rst = 1'b1;
    model_reset();
    #1;
    chk("midrst.gnt", 32'(gnt_w[0]), 32'h00);
    chk("midrst.busy", 32'(busy_w[0]), 32'h0);
    check_all();
    cyc();
    rst = 1'b0;
    req = 8'h21;
    cyc();
    chk("midrst.next", 32'(gnt_w[0]), 32'h01);

    // randomized traffic with occasional resets
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1) req = 8'($urandom);
        else req = 8'($urandom) & 8'($urandom) & 8'($urandom);
      end
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        cyc();
        rst = 1'b0;
      end else begin
        cyc();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
